slave_reader: RTL and testbench

//  Initiator side of the slave_device read protocol. On start, issues one packet of reads
//  (ram_rd_rq + rd_addr 0..PKT_LEN-1), aligns returned data_i bytes by the fixed read latency,

---
 rtl/slave_reader_if.sv | 28 ++
 rtl/slave_reader.sv | 113 +++++++++++
 tb/tb_slave_reader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_reader_if.sv
// Read-initiator bundle: read request/address out, returned byte in, framed payload and header status out.
interface slave_reader_if;
    logic        start;
    logic [7:0]  data_i;
    logic        ram_rd_rq;
    logic [15:0] rd_addr;
    logic        busy;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic [15:0] hdr;
    logic        hdr_valid;
    logic        hdr_err;
    logic        pkt_done;

    modport master (
        input  start, data_i,
        output ram_rd_rq, rd_addr, busy, out_data, out_valid, out_sop, out_eop,
               hdr, hdr_valid, hdr_err, pkt_done
    );

    modport slave (
        output start, data_i,
        input  ram_rd_rq, rd_addr, busy, out_data, out_valid, out_sop, out_eop,
               hdr, hdr_valid, hdr_err, pkt_done
    );
endinterface

// File: rtl/slave_reader.sv
// Reads one PKT_LEN-byte packet per start, realigns data_i by LATENCY, rebuilds/checks the header, frames payload.
// Payload byte k leaves LATENCY+1 cycles after its address; no backpressure, start ignored while busy.
module slave_reader #(
    parameter int PKT_LEN = 16,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst_l,
    slave_reader_if.master bus
);
    localparam logic [15:0] LAST_ADDR  = 16'(PKT_LEN - 1);
    localparam logic [3:0]  DRAIN_LAST = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         drain_cnt;
    logic [LATENCY-1:0] tag_vld;
    logic [15:0]        tag_addr [LATENCY];
    logic [7:0]         hdr_hi;
    logic [15:0]        prev_hdr;
    logic               first_pkt;
    logic               cap_vld;
    logic [15:0]        cap_addr;
    logic [15:0]        new_hdr;

    assign cap_vld  = tag_vld[LATENCY-1];
    assign cap_addr = tag_addr[LATENCY-1];
    assign new_hdr  = {hdr_hi, bus.data_i};

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = REQ;
            REQ:     if (bus.rd_addr == LAST_ADDR) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs are registered from state_nxt so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            drain_cnt     <= '0;
            bus.busy      <= 1'b0;
            bus.ram_rd_rq <= 1'b0;
            bus.rd_addr   <= '0;
            bus.pkt_done  <= 1'b0;
        end else begin
            drain_cnt     <= (state == DRAIN) ? drain_cnt + 4'd1 : 4'd0;
            bus.busy      <= (state_nxt != IDLE);
            bus.ram_rd_rq <= (state_nxt == REQ);
            bus.rd_addr   <= (state == REQ && state_nxt == REQ) ? bus.rd_addr + 16'd1 : 16'd0;
            bus.pkt_done  <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tag_vld       <= '0;
            for (int i = 0; i < LATENCY; i++) tag_addr[i] <= '0;
            hdr_hi        <= '0;
            prev_hdr      <= '0;
            first_pkt     <= 1'b1;
            bus.hdr       <= '0;
            bus.hdr_valid <= 1'b0;
            bus.hdr_err   <= 1'b0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
        end else begin
            tag_vld[0]  <= bus.ram_rd_rq;
            tag_addr[0] <= bus.rd_addr;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_addr[i] <= tag_addr[i-1];
            end
            bus.hdr_valid <= 1'b0;
            bus.hdr_err   <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            if (cap_vld) begin
                if (cap_addr == 16'd0) begin
                    hdr_hi <= bus.data_i;
                end else if (cap_addr == 16'd1) begin
                    // The very first header after reset has no predecessor to compare against.
                    bus.hdr       <= new_hdr;
                    bus.hdr_valid <= 1'b1;
                    bus.hdr_err   <= !first_pkt && (new_hdr != prev_hdr + 16'd1);
                    prev_hdr      <= new_hdr;
                    first_pkt     <= 1'b0;
                end else begin
                    bus.out_data  <= bus.data_i;
                    bus.out_valid <= 1'b1;
                    bus.out_sop   <= (cap_addr == 16'd2);
                    bus.out_eop   <= (cap_addr == LAST_ADDR);
                end
            end
        end
    end
endmodule

// File: tb/tb_slave_reader.sv
// Directed bench: main reader (16 bytes, latency 2) plus two 3-byte readers at latency 1 and 4.
module tb_slave_reader;
    logic clk   = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    slave_reader_if b0 ();
    slave_reader_if b1 ();
    slave_reader_if b2 ();

    slave_reader #(.PKT_LEN(16), .LATENCY(2)) u0 (.clk(clk), .rst_l(rst_l), .bus(b0));
    slave_reader #(.PKT_LEN(3),  .LATENCY(1)) u1 (.clk(clk), .rst_l(rst_l), .bus(b1));
    slave_reader #(.PKT_LEN(3),  .LATENCY(4)) u2 (.clk(clk), .rst_l(rst_l), .bus(b2));

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] mem0 [16];
    logic [7:0] mem1 [4];
    logic [7:0] mem2 [4];

    // Slave model: the address seen in cycle c is answered during cycle c+LATENCY.
    bit [15:0] pa [3][5];
    bit        pv [3][5];
    always @(negedge clk) begin
        for (int i = 4; i > 0; i--) begin
            for (int m = 0; m < 3; m++) begin
                pa[m][i] = pa[m][i-1];
                pv[m][i] = pv[m][i-1];
            end
        end
        pa[0][0] = b0.rd_addr; pv[0][0] = b0.ram_rd_rq;
        pa[1][0] = b1.rd_addr; pv[1][0] = b1.ram_rd_rq;
        pa[2][0] = b2.rd_addr; pv[2][0] = b2.ram_rd_rq;
        b0.data_i = pv[0][2] ? mem0[pa[0][2][3:0]] : 8'h00;
        b1.data_i = pv[1][1] ? mem1[pa[1][1][1:0]] : 8'h00;
        b2.data_i = pv[2][4] ? mem2[pa[2][4][1:0]] : 8'h00;
    end

    // Monitor
    int         cyc = 0, req_cyc = 0, req1 = 0, req2 = 0;
    bit         prev_rq = 0, prev_rq1 = 0, prev_rq2 = 0;
    logic [15:0] addr_q [$];
    logic [7:0]  dat_q [$];
    bit          sop_q [$], eop_q [$], err_q [$];
    int          rel_q [$], gap_q [$];
    logic [15:0] hdr_q [$];
    int          n_done = 0, stray_err = 0, low_run = 0;
    bit          seen_busy = 0;
    int          nb1 = 0, nb2 = 0, rel1 = 0, rel2 = 0;
    logic [9:0]  d1 = '0, d2 = '0;
    always @(negedge clk) begin
        cyc++;
        if (b0.ram_rd_rq) begin
            if (!prev_rq) req_cyc = cyc;
            addr_q.push_back(b0.rd_addr);
        end
        prev_rq = b0.ram_rd_rq;
        if (b0.out_valid) begin
            dat_q.push_back(b0.out_data);
            sop_q.push_back(b0.out_sop);
            eop_q.push_back(b0.out_eop);
            rel_q.push_back(cyc - req_cyc);
        end
        if (b0.hdr_valid) begin
            hdr_q.push_back(b0.hdr);
            err_q.push_back(b0.hdr_err);
        end else if (b0.hdr_err) begin
            stray_err++;
        end
        if (b0.pkt_done) n_done++;
        if (!b0.busy) low_run++;
        else begin
            if (seen_busy && low_run > 0) gap_q.push_back(low_run);
            low_run   = 0;
            seen_busy = 1;
        end
        if (b1.ram_rd_rq && !prev_rq1) req1 = cyc;
        prev_rq1 = b1.ram_rd_rq;
        if (b1.out_valid) begin nb1++; d1 = {b1.out_sop, b1.out_eop, b1.out_data}; rel1 = cyc - req1; end
        if (b2.ram_rd_rq && !prev_rq2) req2 = cyc;
        prev_rq2 = b2.ram_rd_rq;
        if (b2.out_valid) begin nb2++; d2 = {b2.out_sop, b2.out_eop, b2.out_data}; rel2 = cyc - req2; end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin tick(); k++; end while (b0.busy && k < 200);
        if (b0.busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic pulse_start();
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
    endtask

    task automatic load0(input logic [15:0] h, input logic [7:0] base);
        mem0[0] = h[15:8];
        mem0[1] = h[7:0];
        for (int i = 2; i < 16; i++) mem0[i] = base + 8'(i - 2);
    endtask

    task automatic run0(input logic [15:0] h, input logic [7:0] base);
        load0(h, base);
        pulse_start();
        wait_idle();
        repeat (2) tick();
    endtask

    int b_addr, b_dat, b_hdr, b_gap, b_done;
    task automatic mark();
        b_addr = addr_q.size(); b_dat = dat_q.size(); b_hdr = hdr_q.size();
        b_gap  = gap_q.size();  b_done = n_done;
    endtask

    // Checks packet p (counted from the last mark) against the 16-byte / latency-2 timing.
    task automatic chk_pkt(input int p, input logic [15:0] h, input bit err, input logic [7:0] base);
        for (int i = 0; i < 16; i++) chk("rd_addr", addr_q[b_addr + p*16 + i], i);
        for (int j = 0; j < 14; j++) begin
            int k = b_dat + p*14 + j;
            chk("out_data", dat_q[k], base + 8'(j));
            chk("out_sop", sop_q[k], (j == 0));
            chk("out_eop", eop_q[k], (j == 13));
            chk("beat_cycle", rel_q[k], j + 5);
        end
        chk("hdr", hdr_q[b_hdr + p], h);
        chk("hdr_err", err_q[b_hdr + p], err);
    endtask

    task automatic chk_counts(input int npkt);
        chk("n_rq", addr_q.size() - b_addr, npkt * 16);
        chk("n_beats", dat_q.size() - b_dat, npkt * 14);
        chk("n_hdr_valid", hdr_q.size() - b_hdr, npkt);
        chk("n_pkt_done", n_done - b_done, npkt);
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        repeat (2) tick();
        rst_l = 1'b1;
        tick();
    endtask

    initial begin
        b0.start = 0; b1.start = 0; b2.start = 0;
        mem1 = '{8'hAB, 8'hCD, 8'h5A, 8'h00};
        mem2 = '{8'h00, 8'h07, 8'hC3, 8'h00};
        load0(16'h0000, 8'h00);

        // 1: reset state, then one packet
        repeat (3) tick();
        chk("rst_ctrl", {b0.ram_rd_rq, b0.busy, b0.out_valid, b0.out_sop, b0.out_eop,
                         b0.hdr_valid, b0.hdr_err, b0.pkt_done}, 0);
        chk("rst_rd_addr", b0.rd_addr, 0);
        chk("rst_hdr", b0.hdr, 0);
        chk("rst_out_data", b0.out_data, 0);
        rst_l = 1'b1;
        tick();
        mark();
        run0(16'h0001, 8'h10);
        chk_counts(1);
        chk_pkt(0, 16'h0001, 0, 8'h10);
        chk("idle_rd_addr", b0.rd_addr, 0);

        // 2: header continuity 5,6,8
        do_reset();
        mark();
        run0(16'h0005, 8'h50);
        run0(16'h0006, 8'h60);
        run0(16'h0008, 8'h70);
        chk_counts(3);
        chk_pkt(0, 16'h0005, 0, 8'h50);
        chk_pkt(1, 16'h0006, 0, 8'h60);
        chk_pkt(2, 16'h0008, 1, 8'h70);

        // 3: 16-bit wrap is continuous
        do_reset();
        mark();
        run0(16'hFFFF, 8'h80);
        run0(16'h0000, 8'h90);
        chk_counts(2);
        chk_pkt(0, 16'hFFFF, 0, 8'h80);
        chk_pkt(1, 16'h0000, 0, 8'h90);

        // 4: start held high -> back-to-back packets with a single idle cycle
        mark();
        load0(16'h0001, 8'h20);
        b0.start = 1'b1;
        for (int p = 1; p < 3; p++) begin
            wait_idle();
            load0(16'h0001 + 16'(p), 8'h20);
        end
        wait_idle();
        b0.start = 1'b0;
        repeat (4) tick();
        chk_counts(3);
        for (int p = 0; p < 3; p++) chk_pkt(p, 16'h0001 + 16'(p), 0, 8'h20);
        chk("n_gaps", gap_q.size() - b_gap, 3);
        chk("gap1", gap_q[b_gap + 1], 1);
        chk("gap2", gap_q[b_gap + 2], 1);

        // 4b: start pulses during REQ and DRAIN are dropped
        mark();
        load0(16'h0004, 8'h30);
        pulse_start();
        repeat (5) tick();
        pulse_start();
        repeat (10) tick();
        pulse_start();
        wait_idle();
        repeat (4) tick();
        chk_counts(1);
        chk_pkt(0, 16'h0004, 0, 8'h30);

        // 5: reset in the middle of REQ
        load0(16'h0777, 8'hA0);
        pulse_start();
        begin
            int k = 0;
            while (b0.rd_addr != 16'd6 && k < 40) begin tick(); k++; end
            chk("reach_addr6", b0.rd_addr, 6);
        end
        rst_l = 1'b0;
        #1;
        chk("abort_ctrl", {b0.ram_rd_rq, b0.busy, b0.out_valid, b0.hdr_valid, b0.pkt_done}, 0);
        chk("abort_rd_addr", b0.rd_addr, 0);
        chk("abort_hdr", b0.hdr, 0);
        repeat (2) tick();
        rst_l = 1'b1;
        mark();
        repeat (30) tick();
        chk("abort_beats", dat_q.size() - b_dat, 0);
        chk("abort_done", n_done - b_done, 0);
        chk("abort_hdr_valid", hdr_q.size() - b_hdr, 0);
        run0(16'h1234, 8'h40);
        chk_counts(1);
        chk_pkt(0, 16'h1234, 0, 8'h40);

        // 6: 3-byte packets at latency 1 and 4
        b1.start = 1'b1; b2.start = 1'b1;
        tick();
        b1.start = 1'b0; b2.start = 1'b0;
        repeat (15) tick();
        chk("l1_beats", nb1, 1);
        chk("l1_beat", d1, {2'b11, 8'h5A});
        chk("l1_cycle", rel1, 4);
        chk("l1_hdr", b1.hdr, 16'hABCD);
        chk("l4_beats", nb2, 1);
        chk("l4_beat", d2, {2'b11, 8'hC3});
        chk("l4_cycle", rel2, 7);
        chk("l4_hdr", b2.hdr, 16'h0007);

        chk("stray_hdr_err", stray_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
